// File: rtl/pwm_compare.sv
// Registered PWM comparator behind the period counter.
// Duty updates are double-buffered and applied only at a period start.
module pwm_compare #(
  parameter int unsigned NBIT       = 5,
  parameter int unsigned MAXCOUNT   = 30,
  parameter int unsigned DUTY_RESET = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [NBIT-1:0] count_in,
  input  logic [NBIT:0] duty_in,
  input  logic          duty_valid,
  output logic          duty_ready,
  output logic          pwm_out,
  output logic          period_tick,
  output logic [NBIT:0] duty_active
);

  localparam logic [NBIT:0]   DMAX  = (NBIT+1)'(MAXCOUNT + 1);
  localparam logic [NBIT:0]   DRST  = (NBIT+1)'(DUTY_RESET);
  localparam logic [NBIT-1:0] CPRST = NBIT'(MAXCOUNT);

  logic [NBIT-1:0] cprev_q;
  logic [NBIT:0]   pend_q, pend_d;
  logic            pflag_q, pflag_d;
  logic [NBIT:0]   duty_q, duty_d;
  logic            pwm_q, pwm_d;
  logic            tick_q, tick_d;

  logic            bnd;
  logic            start;
  logic            load;
  logic            hs;
  logic [NBIT:0]   clamped;
  logic [NBIT:0]   duty_eff;

  assign bnd     = (count_in == '0) && (cprev_q != '0);
  assign start   = bnd && enable;
  assign load    = start && pflag_q;
  assign hs      = duty_valid && !pflag_q;
  assign clamped = (duty_in > DMAX) ? DMAX : duty_in;
  // A loading boundary compares against the incoming duty, not the old one.
  assign duty_eff = load ? pend_q : duty_q;

  always_comb begin
    pend_d  = pend_q;
    pflag_d = pflag_q;
    duty_d  = duty_q;
    if (load) begin
      duty_d  = pend_q;
      pflag_d = 1'b0;
    end else if (hs) begin
      pend_d  = clamped;
      pflag_d = 1'b1;
    end
    pwm_d  = enable && ({1'b0, count_in} < duty_eff);
    tick_d = start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cprev_q <= CPRST;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      duty_q  <= DRST;
      pwm_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cprev_q <= count_in;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
    end
  end

  assign duty_ready  = !pflag_q;
  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign duty_active = duty_q;

endmodule
